// File: rtl/card_deal_anim_if.sv
// Deal-request handshake between the game FSM (master) and the card animation sequencer (slave).
// A request transfers on any clock edge where req_valid and req_ready are both high.
interface card_deal_anim_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_dest;
    logic [2:0] req_slot;

    modport master (
        output req_valid,
        output req_dest,
        output req_slot,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_dest,
        input  req_slot,
        output req_ready
    );
endinterface

// File: rtl/card_deal_anim_ctrl.sv
// Sequences one card-deal animation at a time: walks the sprite from the deck to a table slot once per frame.
// Define ANIM_QUEUE_EN to place a 2-entry request FIFO in front of the sequencer.
module card_deal_anim_ctrl #(
    parameter int DECK_X     = 560,
    parameter int DECK_Y     = 40,
    parameter int PLAYER_Y   = 400,
    parameter int DEALER_Y   = 120,
    parameter int SLOT_X0    = 100,
    parameter int SLOT_PITCH = 64,
    parameter int STEP       = 8,
    parameter int ROT_FRAMES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   vblnk_in,
    card_deal_anim_if.slave        req,
    input  logic                   abort,
    output logic [11:0]            xpos,
    output logic [11:0]            ypos,
    output logic [1:0]             angle,
    output logic [2:0]             animation,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [11:0] DECK_X_W   = 12'(DECK_X);
    localparam logic [11:0] DECK_Y_W   = 12'(DECK_Y);
    localparam logic [11:0] PLAYER_Y_W = 12'(PLAYER_Y);
    localparam logic [11:0] DEALER_Y_W = 12'(DEALER_Y);
    localparam logic [11:0] SLOT_X0_W  = 12'(SLOT_X0);
    localparam logic [11:0] PITCH_W    = 12'(SLOT_PITCH);
    localparam logic [11:0] STEP_W     = 12'(STEP);
    localparam logic [7:0]  ROT_LIM    = 8'(ROT_FRAMES);

    localparam logic [1:0] ANGLE_SIDE    = 2'b01;
    localparam logic [1:0] ANGLE_UPRIGHT = 2'b00;
    localparam logic [2:0] ANIM_IDLE     = 3'd0;
    localparam logic [2:0] ANIM_PLAYER   = 3'd1;
    localparam logic [2:0] ANIM_DEALER   = 3'd2;
    localparam logic [2:0] ANIM_HOLD     = 3'd3;

    state_t      state_q, state_d;
    logic [11:0] xpos_q, xpos_d;
    logic [11:0] ypos_q, ypos_d;
    logic [11:0] tx_q, tx_d;
    logic [11:0] ty_q, ty_d;
    logic [1:0]  angle_q, angle_d;
    logic [2:0]  anim_q, anim_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        req_ready_q, req_ready_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        vblnk_q, vblnk_d;

    logic        tick;
    logic        start;
    logic        start_dest;
    logic [2:0]  start_slot;

`ifdef ANIM_QUEUE_EN
    logic [1:0]      fifo_dest_q, fifo_dest_d;
    logic [1:0][2:0] fifo_slot_q, fifo_slot_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [1:0]      count_q, count_d;
    logic            push;
    logic            pop;
`endif

    assign tick = vblnk_in & ~vblnk_q;

    assign req.req_ready = req_ready_q;
    assign xpos          = xpos_q;
    assign ypos          = ypos_q;
    assign angle         = angle_q;
    assign animation     = anim_q;
    assign busy          = busy_q;
    assign done          = done_q;

    // Moves one coordinate toward its target by at most STEP, snapping when within reach so it never overshoots.
    function automatic logic [11:0] step_axis(input logic [11:0] cur, input logic [11:0] tgt);
        logic [11:0] diff;
        if (cur < tgt) begin
            diff      = tgt - cur;
            step_axis = (diff <= STEP_W) ? tgt : cur + STEP_W;
        end else begin
            diff      = cur - tgt;
            step_axis = (diff <= STEP_W) ? tgt : cur - STEP_W;
        end
    endfunction

    always_comb begin
        state_d     = state_q;
        xpos_d      = xpos_q;
        ypos_d      = ypos_q;
        tx_d        = tx_q;
        ty_d        = ty_q;
        angle_d     = angle_q;
        anim_d      = anim_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;
        vblnk_d     = vblnk_in;

`ifdef ANIM_QUEUE_EN
        fifo_dest_d = fifo_dest_q;
        fifo_slot_d = fifo_slot_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        push        = req.req_valid & req_ready_q;
        pop         = (state_q == IDLE) && (count_q != 2'd0);
        if (push) begin
            fifo_dest_d[wr_ptr_q] = req.req_dest;
            fifo_slot_d[wr_ptr_q] = req.req_slot;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d    = count_q + 2'(push) - 2'(pop);
        start      = pop;
        start_dest = fifo_dest_q[rd_ptr_q];
        start_slot = fifo_slot_q[rd_ptr_q];
`else
        start      = req.req_valid & req_ready_q;
        start_dest = req.req_dest;
        start_slot = req.req_slot;
`endif

        unique case (state_q)
            IDLE: begin
                xpos_d  = DECK_X_W;
                ypos_d  = DECK_Y_W;
                angle_d = ANGLE_SIDE;
                anim_d  = ANIM_IDLE;
                busy_d  = 1'b0;
                if (start) begin
                    state_d     = MOVE;
                    tx_d        = SLOT_X0_W + 12'(start_slot) * PITCH_W;
                    ty_d        = start_dest ? DEALER_Y_W : PLAYER_Y_W;
                    anim_d      = start_dest ? ANIM_DEALER : ANIM_PLAYER;
                    busy_d      = 1'b1;
                    frame_cnt_d = '0;
                end
            end

            MOVE: begin
                if (abort) begin
                    state_d = IDLE;
                    xpos_d  = DECK_X_W;
                    ypos_d  = DECK_Y_W;
                    angle_d = ANGLE_SIDE;
                    anim_d  = ANIM_IDLE;
                    busy_d  = 1'b0;
                end else if (tick) begin
                    xpos_d = step_axis(xpos_q, tx_q);
                    ypos_d = step_axis(ypos_q, ty_q);
                    if (frame_cnt_q < ROT_LIM) begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                    angle_d = (frame_cnt_d < ROT_LIM) ? ANGLE_SIDE : ANGLE_UPRIGHT;
                    if ((xpos_d == tx_q) && (ypos_d == ty_q)) begin
                        state_d = HOLD;
                        anim_d  = ANIM_HOLD;
                        angle_d = ANGLE_UPRIGHT;
                    end
                end
            end

            HOLD: begin
                // The landed card stays on screen for one frame; completion is only reported if not aborted.
                if (abort || tick) begin
                    state_d = IDLE;
                    xpos_d  = DECK_X_W;
                    ypos_d  = DECK_Y_W;
                    angle_d = ANGLE_SIDE;
                    anim_d  = ANIM_IDLE;
                    busy_d  = 1'b0;
                    done_d  = ~abort;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef ANIM_QUEUE_EN
        req_ready_d = (count_d != 2'd2);
`else
        req_ready_d = (state_d == IDLE) && !done_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            xpos_q      <= DECK_X_W;
            ypos_q      <= DECK_Y_W;
            tx_q        <= DECK_X_W;
            ty_q        <= DECK_Y_W;
            angle_q     <= ANGLE_SIDE;
            anim_q      <= ANIM_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            req_ready_q <= 1'b1;
            frame_cnt_q <= '0;
            vblnk_q     <= 1'b0;
`ifdef ANIM_QUEUE_EN
            fifo_dest_q <= '0;
            fifo_slot_q <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            xpos_q      <= xpos_d;
            ypos_q      <= ypos_d;
            tx_q        <= tx_d;
            ty_q        <= ty_d;
            angle_q     <= angle_d;
            anim_q      <= anim_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            req_ready_q <= req_ready_d;
            frame_cnt_q <= frame_cnt_d;
            vblnk_q     <= vblnk_d;
`ifdef ANIM_QUEUE_EN
            fifo_dest_q <= fifo_dest_d;
            fifo_slot_q <= fifo_slot_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
`endif
        end
    end

endmodule

// File: tb/tb_card_deal_anim_ctrl.sv
// Directed bench for card_deal_anim_ctrl (default build, no request queue).
// Expected positions are hand-computed from deck (560,40), slot pitch 64, step 8, 4 sideways frames.
module tb_card_deal_anim_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        vblnk_in;
    logic        abort;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic [1:0]  angle;
    logic [2:0]  animation;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    card_deal_anim_if req_if ();

    card_deal_anim_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .vblnk_in  (vblnk_in),
        .req       (req_if),
        .abort     (abort),
        .xpos      (xpos),
        .ypos      (ypos),
        .angle     (angle),
        .animation (animation),
        .busy      (busy),
        .done      (done)
    );

    // Counts done pulses using the value held over the preceding cycle.
    always @(posedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int x, input int y, input int ang,
                             input int anim, input int bsy, input int rdy, input int dn);
        check_output({tag, ".xpos"},      xpos,              x);
        check_output({tag, ".ypos"},      ypos,              y);
        check_output({tag, ".angle"},     angle,             ang);
        check_output({tag, ".animation"}, animation,         anim);
        check_output({tag, ".busy"},      busy,              bsy);
        check_output({tag, ".req_ready"}, req_if.req_ready,  rdy);
        check_output({tag, ".done"},      done,              dn);
    endtask

    // One frame: a single tick, returning at a negedge with the update already visible.
    task automatic apply_frame();
        @(negedge clk) vblnk_in = 1'b1;
        @(negedge clk) vblnk_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic apply_request(input logic dest, input logic [2:0] slot);
        @(negedge clk);
        req_if.req_valid = 1'b1;
        req_if.req_dest  = dest;
        req_if.req_slot  = slot;
        @(negedge clk);
        req_if.req_valid = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        vblnk_in         = 1'b0;
        abort            = 1'b0;
        req_if.req_valid = 1'b0;
        req_if.req_dest  = 1'b0;
        req_if.req_slot  = 3'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all("reset", 560, 40, 1, 0, 0, 1, 0);

        repeat (3) apply_frame();
        check_all("idle3", 560, 40, 1, 0, 0, 1, 0);
        check_output("idle_done_cnt", done_cnt, 0);

        $display("[TB] player slot 2 -> (228,400)");
        apply_request(1'b0, 3'd2);
        check_all("p2_accept", 560, 40, 1, 1, 1, 0, 0);
        for (int i = 1; i <= 46; i++) begin
            apply_frame();
            if (i == 1)  check_all("p2_t1", 552, 48, 1, 1, 1, 0, 0);
            if (i == 3)  check_output("p2_t3.angle", angle, 1);
            if (i == 4)  check_output("p2_t4.angle", angle, 0);
            if (i == 41) check_output("p2_t41.xpos", xpos, 232);
            if (i == 42) begin
                check_output("p2_t42.xpos", xpos, 228);
                check_output("p2_t42.ypos", ypos, 376);
            end
            if (i == 44) begin
                check_output("p2_t44.ypos", ypos, 392);
                check_output("p2_t44.animation", animation, 1);
            end
            if (i == 45) check_all("p2_t45", 228, 400, 0, 3, 1, 0, 0);
            if (i == 46) check_all("p2_t46", 560, 40, 1, 0, 0, 1, 0);
        end
        check_output("p2_done_cnt", done_cnt, 1);

        $display("[TB] dealer slot 0 -> (100,120)");
        apply_request(1'b1, 3'd0);
        check_all("d0_accept", 560, 40, 1, 2, 1, 0, 0);
        for (int i = 1; i <= 59; i++) begin
            apply_frame();
            if (i == 10) check_all("d0_t10", 480, 120, 1'b0, 2, 1, 0, 0);
            if (i == 57) check_all("d0_t57", 104, 120, 0, 2, 1, 0, 0);
            if (i == 58) check_all("d0_t58", 100, 120, 0, 3, 1, 0, 0);
            if (i == 59) check_all("d0_t59", 560, 40, 1, 0, 0, 1, 0);
        end
        check_output("d0_done_cnt", done_cnt, 2);

        $display("[TB] abort together with tick 20 of player slot 7");
        apply_request(1'b0, 3'd7);
        repeat (19) apply_frame();
        check_all("ab_t19", 548, 192, 0, 1, 1, 0, 0);
        @(negedge clk);
        vblnk_in = 1'b1;
        abort    = 1'b1;
        @(negedge clk);
        vblnk_in = 1'b0;
        abort    = 1'b0;
        check_all("ab_next", 560, 40, 1, 0, 0, 1, 0);
        apply_frame();
        check_all("ab_frame", 560, 40, 1, 0, 0, 1, 0);
        check_output("ab_done_cnt", done_cnt, 2);

        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check_all("abort_idle", 560, 40, 1, 0, 0, 1, 0);

        $display("[TB] request held while busy, accepted after done");
        apply_request(1'b0, 3'd1);
        check_all("hb_accept", 560, 40, 1, 1, 1, 0, 0);
        @(negedge clk);
        req_if.req_valid = 1'b1;
        req_if.req_dest  = 1'b1;
        req_if.req_slot  = 3'd3;
        for (int i = 1; i <= 50; i++) begin
            apply_frame();
            if (i == 5) begin
                check_output("hb_t5.req_ready", req_if.req_ready, 0);
                check_output("hb_t5.animation", animation, 1);
            end
            if (i == 49) check_all("hb_t49", 168, 400, 0, 1, 1, 0, 0);
            if (i == 50) check_all("hb_t50", 164, 400, 0, 3, 1, 0, 0);
        end
        @(negedge clk) vblnk_in = 1'b1;
        @(negedge clk) vblnk_in = 1'b0;
        check_all("hb_done_cycle", 560, 40, 1, 0, 0, 0, 1);
        @(negedge clk);
        check_all("hb_ready_after_done", 560, 40, 1, 0, 0, 1, 0);
        @(negedge clk);
        req_if.req_valid = 1'b0;
        check_all("hb_held_accept", 560, 40, 1, 2, 1, 0, 0);
        apply_frame();
        check_all("hb_d3_t1", 552, 48, 1, 2, 1, 0, 0);
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check_all("hb_abort_move", 560, 40, 1, 0, 0, 1, 0);
        check_output("hb_done_cnt", done_cnt, 3);

        $display("[TB] reset in the middle of player slot 4");
        apply_request(1'b0, 3'd4);
        repeat (3) apply_frame();
        check_output("rst_mid.xpos_before", xpos, 536);
        check_output("rst_mid.ypos_before", ypos, 64);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        check_all("rst_mid", 560, 40, 1, 0, 0, 1, 0);
        rst = 1'b0;
        repeat (2) apply_frame();
        check_all("rst_after", 560, 40, 1, 0, 0, 1, 0);
        check_output("final_done_cnt", done_cnt, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
